// File: rtl/uart_tx_periph_pkg.sv
// Shared bus encodings, UART register offsets, STATUS bit indices and TX FSM states.
package uart_tx_periph_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam logic [1:0] REQW_B = 2'b00;
    localparam logic [1:0] REQW_H = 2'b01;
    localparam logic [1:0] REQW_W = 2'b10;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVERRUN   = 3;
    localparam int unsigned STAT_LEVEL_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic logic [3:0] sat_nibble(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO and bit serialiser.
// Optional interrupt output is enabled by defining UART_TX_IRQ_EN.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [1:0]  reqw,
    input  logic [1:0]  mode,
    input  logic        reqs,
    output logic [31:0] read_data,
    output logic        txd,
    output logic        irq
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RESET = (DEFAULT_DIV == 0) ? 16'd1 : 16'(DEFAULT_DIV);

    logic [3:0]    offset;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic [7:0]    pop_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [15:0]   div_reg;
    logic          enable;
    logic          overrun;
    logic          ctrl_irq_en;
    logic          busy;

    tx_state_t   state, state_n;
    logic [15:0] bit_cnt, bit_cnt_n;
    logic [15:0] bit_div, bit_div_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        bit_done;

    logic unused_bus;
    assign unused_bus = ^{address[31:4], write_data[31:16], reqw, reqs};

    assign offset = address[3:0];
    assign wr_en  = select && (mode == MODE_WRITE) && (address[1:0] == 2'b00);
    assign push   = wr_en && (offset == UART_DATA);
    assign busy   = (state != TX_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (write_data[7:0]),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DIV_RESET;
            enable  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                case (offset)
                    UART_STATUS: if (write_data[STAT_OVERRUN]) overrun <= 1'b0;
                    UART_DIV:    div_reg <= (write_data[15:0] == '0) ? 16'd1 : write_data[15:0];
                    UART_CTRL:   enable  <= write_data[0];
                    default:     ;
                endcase
            end
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en;
    logic irq_en_n;
    logic irq_q;

    assign irq_en_n = (wr_en && (offset == UART_CTRL)) ? write_data[1] : irq_en;

    // A push in the current cycle suppresses irq immediately rather than one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            irq_q  <= irq_en_n && empty && !busy && !push;
        end
    end

    assign ctrl_irq_en = irq_en;
    assign irq         = irq_q;
`else
    assign ctrl_irq_en = 1'b0;
    assign irq         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            bit_cnt <= '0;
            bit_div <= DIV_RESET;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_div <= bit_div_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // bit_div is resampled from DIV only at bit boundaries so a divisor write never stretches a bit.
    assign bit_done = (bit_cnt == bit_div - 16'd1);

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_div_n = bit_div;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            TX_IDLE: begin
                if (enable && !empty) begin
                    pop       = 1'b1;
                    shift_n   = pop_data;
                    bit_cnt_n = '0;
                    bit_div_n = div_reg;
                    state_n   = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    bit_cnt_n = '0;
                    bit_div_n = div_reg;
                    bit_idx_n = '0;
                    state_n   = TX_DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    bit_cnt_n = '0;
                    bit_div_n = div_reg;
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    bit_cnt_n = '0;
                    state_n   = TX_IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = shift[0];
            default:  txd = 1'b1;
        endcase
    end

    always_comb begin
        read_data = '0;
        if (select && (mode == MODE_READ)) begin
            case (offset)
                UART_STATUS: begin
                    read_data[STAT_BUSY]    = busy;
                    read_data[STAT_FULL]    = full;
                    read_data[STAT_EMPTY]   = empty;
                    read_data[STAT_OVERRUN] = overrun;
                    read_data[STAT_LEVEL_LSB +: 4] = sat_nibble(32'(level));
                end
                UART_DIV:  read_data[15:0] = div_reg;
                UART_CTRL: read_data[1:0]  = {ctrl_irq_en, enable};
                default:   read_data = '0;
            endcase
        end
    end

endmodule
